// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule definitions: FSM encoding, round constants, sizes.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package aes_pkg;

  localparam int NR       = 10;
  localparam int NB_BYTES = 16;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    READY,
    STREAM,
    EXPAND,
    DONE
  } state_t;

  // Round constant for the round being produced (1..10); other indices give 00.
  function automatic logic [7:0] rcon(input logic [3:0] rnd);
    logic [7:0] val;
    case (rnd)
      4'd1:    val = 8'h01;
      4'd2:    val = 8'h02;
      4'd3:    val = 8'h04;
      4'd4:    val = 8'h08;
      4'd5:    val = 8'h10;
      4'd6:    val = 8'h20;
      4'd7:    val = 8'h40;
      4'd8:    val = 8'h80;
      4'd9:    val = 8'h1b;
      4'd10:   val = 8'h36;
      default: val = 8'h00;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box, one byte in, one byte out.
// Latency: combinational.
// Backpressure: none.
module aes_sbox (
  input  logic [7:0] din,
  output logic [7:0] dout
);

  localparam logic [0:255][7:0] SBOX = {
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign dout = SBOX[din];

endmodule

// File: rtl/aes_key_expand.sv
// AES-128 on-the-fly key expansion: byte-serial key load, byte-serial round-key stream.
// Latency: next -> byte 0 one cycle later, 16 bytes back to back; 4-cycle expand between rounds.
// Backpressure: none on the stream; the consumer paces rounds with next, offered only while ready.
module aes_key_expand #(
  parameter int NR = 10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       key_valid,
  input  logic [7:0] key_in,
  input  logic       next,
  output logic [7:0] rk_byte,
  output logic       rk_valid,
  output logic [3:0] round_idx,
  output logic       ready,
  output logic       done
);

  import aes_pkg::*;

  state_t        state;
  state_t        state_nxt;
  logic [127:0]  key_q;      // current round key, word 0 / byte 0 in the MSBs
  logic [3:0]    cnt;        // byte counter in LOAD/STREAM, word counter in EXPAND
  logic [31:0]   rot_word;
  logic [31:0]   sub_word;
  logic [31:0]   temp_word;
  logic [31:0]   new_word;

  // SubWord(RotWord(last word)): rotate left one byte, then four parallel S-boxes.
  assign rot_word = {key_q[23:0], key_q[31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (
      .din  (rot_word[8*g +: 8]),
      .dout (sub_word[8*g +: 8])
    );
  end

  // key_q is used as a 4-word window: MSW is w[i-4], LSW is w[i-1], so every
  // expand step is the same shift regardless of which word is being produced.
  assign temp_word = (cnt[1:0] == 2'd0) ? (sub_word ^ {rcon(round_idx + 4'd1), 24'h000000})
                                        : key_q[31:0];
  assign new_word  = key_q[127:96] ^ temp_word;

  assign rk_valid = (state == STREAM);
  assign rk_byte  = rk_valid ? key_q[127:120] : 8'h00;
  assign ready    = (state == READY);
  assign done     = (state == DONE);

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode; stray start/next/key_valid outside their states fall through.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = LOAD;
      LOAD:       if (key_valid && cnt == 4'(NB_BYTES - 1)) state_nxt = READY;
      READY:      if (next) state_nxt = STREAM;
      STREAM: begin
        if (cnt == 4'(NB_BYTES - 1)) state_nxt = (round_idx == 4'(NR)) ? DONE : EXPAND;
      end
      EXPAND:     if (cnt == 4'd3) state_nxt = READY;
      default:    state_nxt = IDLE;
    endcase
  end

  // Key register, counters and round index.
  always_ff @(posedge clock) begin
    if (reset) begin
      key_q     <= '0;
      cnt       <= '0;
      round_idx <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            cnt       <= '0;
            round_idx <= '0;
          end
        end
        LOAD: begin
          if (key_valid) begin
            key_q <= {key_q[119:0], key_in};
            cnt   <= cnt + 4'd1;
          end
        end
        STREAM: begin
          // Rotate so the outgoing byte is always the MSB; 16 rotations restore the key.
          key_q <= {key_q[119:0], key_q[127:120]};
          cnt   <= cnt + 4'd1;
        end
        EXPAND: begin
          key_q <= {key_q[95:0], new_word};
          if (cnt == 4'd3) begin
            cnt       <= '0;
            round_idx <= round_idx + 4'd1;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_key_expand.sv
// Directed bench for aes_key_expand using FIPS-197 key-schedule vectors.
// Latency: checks next->byte0 of one cycle, 16-byte streams and 4-cycle expand.
// Backpressure: checks that start/next/key_valid are ignored outside their states.
module tb_aes_key_expand;

  logic       clock;
  logic       reset;
  logic       start;
  logic       key_valid;
  logic [7:0] key_in;
  logic       next;
  logic [7:0] rk_byte;
  logic       rk_valid;
  logic [3:0] round_idx;
  logic       ready;
  logic       done;

  int n_cmp = 0;
  int n_err = 0;

  aes_key_expand #(.NR(10)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .key_valid (key_valid),
    .key_in    (key_in),
    .next      (next),
    .rk_byte   (rk_byte),
    .rk_valid  (rk_valid),
    .round_idx (round_idx),
    .ready     (ready),
    .done      (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Start a load and feed 16 bytes; optional gaps carry stray next pulses.
  task automatic load_key(input logic [127:0] key, input bit gappy, input string tag);
    int gaps;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (gappy) begin
        gaps = $urandom_range(0, 2);
        for (int g = 0; g < gaps; g++) begin
          key_valid = 1'b0;
          next      = 1'b1;
          tick();
        end
        next = 1'b0;
      end
      key_valid = 1'b1;
      key_in    = key[127 - 8*i -: 8];
      if (i == 15) chk({tag, "_ready_before_last"}, 128'(ready), 128'd0);
      tick();
    end
    key_valid = 1'b0;
    key_in    = 8'h00;
    chk({tag, "_ready_after_last"}, 128'(ready), 128'd1);
    chk({tag, "_round_idx_loaded"}, 128'(round_idx), 128'd0);
  endtask

  // Request a round key and collect the contiguous burst of valid bytes.
  task automatic do_stream(input bit poke, output logic [127:0] got, output int len);
    got = '0;
    len = 0;
    next = 1'b1;
    tick();
    next = 1'b0;
    for (int c = 0; c < 24; c++) begin
      if (rk_valid) begin
        got = {got[119:0], rk_byte};
        len++;
      end else if (len > 0) begin
        break;
      end
      next = poke && (len == 5);
      tick();
    end
    next = 1'b0;
  endtask

  // Bounded wait for ready; returns the number of cycles waited.
  task automatic wait_ready(input string tag, output int n);
    n = 0;
    while (!ready && n < 12) begin
      tick();
      n++;
    end
    chk({tag, "_ready_reached"}, 128'(ready), 128'd1);
  endtask

  initial begin
    logic [127:0] key_a;
    logic [127:0] key_b;
    logic [127:0] got;
    int           len;
    int           nw;

    key_a = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    key_b = 128'h000102030405060708090a0b0c0d0e0f;

    reset     = 1'b1;
    start     = 1'b0;
    key_valid = 1'b0;
    key_in    = 8'h00;
    next      = 1'b0;
    repeat (3) tick();
    chk("rst_rk_valid",  128'(rk_valid),  128'd0);
    chk("rst_rk_byte",   128'(rk_byte),   128'd0);
    chk("rst_ready",     128'(ready),     128'd0);
    chk("rst_done",      128'(done),      128'd0);
    chk("rst_round_idx", 128'(round_idx), 128'd0);
    reset = 1'b0;

    // Round 0 and round 1 of key A, with stray next pulses in EXPAND and STREAM.
    load_key(key_a, 1'b0, "a_load");
    next = 1'b1;
    tick();
    next = 1'b0;
    chk("a_r0_first_byte_valid", 128'(rk_valid), 128'd1);
    chk("a_r0_first_byte",       128'(rk_byte),  128'h2b);
    got = 128'h2b;
    len = 1;
    for (int c = 0; c < 20 && rk_valid; c++) begin
      tick();
      if (rk_valid) begin
        got = {got[119:0], rk_byte};
        len++;
      end
    end
    chk("a_r0_key", got, key_a);
    chk("a_r0_len", 128'(len), 128'd16);
    chk("expand_rk_byte_zero", 128'(rk_byte), 128'd0);
    next = 1'b1;
    tick();
    next = 1'b0;
    nw = 1;
    while (!ready && nw < 12) begin
      tick();
      nw++;
    end
    chk("expand_cycles", 128'(nw), 128'd4);
    chk("a_round_idx_1", 128'(round_idx), 128'd1);

    do_stream(1'b1, got, len);
    chk("a_r1_key", got, 128'ha0fafe1788542cb123a339392a6c7605);
    chk("a_r1_len_with_poke", 128'(len), 128'd16);
    wait_ready("a_r1", nw);
    chk("a_round_idx_2", 128'(round_idx), 128'd2);

    for (int r = 2; r < 10; r++) begin
      do_stream(1'b0, got, len);
      wait_ready("a_mid", nw);
    end
    chk("a_round_idx_10", 128'(round_idx), 128'd10);
    do_stream(1'b0, got, len);
    chk("a_r10_key", got, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    chk("a_r10_len", 128'(len), 128'd16);
    chk("a_done_set", 128'(done), 128'd1);
    repeat (3) tick();
    chk("a_done_held", 128'(done), 128'd1);
    chk("a_done_rk_valid", 128'(rk_valid), 128'd0);

    // Restart from DONE with key B and run it to round 10.
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("b_done_cleared", 128'(done), 128'd0);
    for (int i = 0; i < 16; i++) begin
      key_valid = 1'b1;
      key_in    = key_b[127 - 8*i -: 8];
      tick();
    end
    key_valid = 1'b0;
    chk("b_ready", 128'(ready), 128'd1);
    do_stream(1'b0, got, len);
    chk("b_r0_key", got, key_b);
    wait_ready("b_r0", nw);
    for (int r = 1; r < 10; r++) begin
      do_stream(1'b0, got, len);
      wait_ready("b_mid", nw);
    end
    do_stream(1'b0, got, len);
    chk("b_r10_key", got, 128'h13111d7fe3944a17f307a78b4d2b30c5);
    chk("b_done_set", 128'(done), 128'd1);

    // Gapped reload of key A with next pulses during LOAD.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    load_key(key_a, 1'b1, "g_load");
    do_stream(1'b0, got, len);
    chk("g_r0_key", got, key_a);
    wait_ready("g_r0", nw);
    do_stream(1'b0, got, len);
    chk("g_r1_key", got, 128'ha0fafe1788542cb123a339392a6c7605);
    wait_ready("g_r1", nw);

    // Reset in the middle of the round 5 stream.
    for (int r = 2; r < 5; r++) begin
      do_stream(1'b0, got, len);
      wait_ready("m_mid", nw);
    end
    chk("m_round_idx_5", 128'(round_idx), 128'd5);
    next = 1'b1;
    tick();
    next = 1'b0;
    repeat (7) tick();
    chk("m_streaming_at_byte7", 128'(rk_valid), 128'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("m_rst_rk_valid",  128'(rk_valid),  128'd0);
    chk("m_rst_round_idx", 128'(round_idx), 128'd0);
    chk("m_rst_ready",     128'(ready),     128'd0);
    chk("m_rst_rk_byte",   128'(rk_byte),   128'd0);
    load_key(key_a, 1'b0, "m_load");
    do_stream(1'b0, got, len);
    wait_ready("m_r0", nw);
    do_stream(1'b0, got, len);
    chk("m_r1_key", got, 128'ha0fafe1788542cb123a339392a6c7605);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/aes_key_expand.md
AES_KEY_EXPAND -- requirements
Module: aes_key_expand

Interface
REQ-001 Parameter NR, default 10: number of AES-128 rounds after round 0; fixed at 10 for this block.
REQ-002 Clock and reset: one clock; reset is synchronous and active-high.
REQ-003 Port clock, input, 1: rising-edge clock for all state.
REQ-004 Port reset, input, 1: synchronous active-high reset.
REQ-005 Port start, input, 1: one-cycle pulse that begins a key load.
REQ-006 Port key_valid, input, 1: key_in carries a valid cipher-key byte this cycle.
REQ-007 Port key_in, input, 8: cipher-key byte, byte 0 (MSB of the 128-bit key) first.
REQ-008 Port next, input, 1: request to stream the current round key.
REQ-009 Port rk_byte, output, 8: round-key byte, byte 0 first, feeding the encrypt core's key input.
REQ-010 Port rk_valid, output, 1: rk_byte is valid this cycle.
REQ-011 Port round_idx, output, 4: index (0..10) of the round key currently held or streaming.
REQ-012 Port ready, output, 1: a round key is available and next will be accepted.
REQ-013 Port done, output, 1: round key 10 has been fully streamed.

Function
REQ-014 FSM states: IDLE, LOAD, READY, STREAM, EXPAND, DONE.
REQ-015 IDLE/DONE: start moves the FSM to LOAD, clears the byte counter, and sets round_idx to 0; start in any other state is ignored.
REQ-016 LOAD: each key_valid cycle shifts key_in into the 128-bit key register; after the 16th accepted byte the FSM enters READY on the next cycle; gaps in key_valid are allowed.
REQ-017 key_valid outside LOAD is ignored.
REQ-018 READY: ready=1; next moves the FSM to STREAM; next in any other state is ignored.
REQ-019 STREAM latency: next sampled at edge t gives rk_byte byte 0 with rk_valid=1 during cycle t+1, and bytes 1..15 on the following 15 consecutive cycles, with no stalls.
REQ-020 After byte 15: if round_idx<10, the FSM enters EXPAND; if round_idx=10, it enters DONE with done=1 held until start or reset.
REQ-021 EXPAND lasts exactly 4 cycles and computes one 32-bit word per cycle, w[i] = w[i-4] XOR t.
REQ-022 For word 0 of a round, t = SubWord(RotWord(w[i-1])) XOR {Rcon[round_idx+1],00,00,00}; for words 1..3, t = w[i-1] (the word computed in the previous cycle).
REQ-023 At the end of EXPAND, round_idx increments and the FSM enters READY.
REQ-024 Rcon values for rounds 1..10: 01,02,04,08,10,20,40,80,1B,36.
REQ-025 rk_valid=0 and rk_byte=00 in every state other than STREAM.
REQ-026 ready=1 only in READY.
REQ-027 All arithmetic is bitwise XOR on 8-bit or 32-bit words; there is no carry.
REQ-028 Both round-key streaming orders and the key register byte order follow FIPS-197 (column-major, byte 0 = key[127:120]).

Reset
REQ-029 Reset forces IDLE and clears the key register, counters, and round_idx to 0, and rk_byte, rk_valid, ready, and done to 0, from any state including mid-LOAD, mid-STREAM, and mid-EXPAND.
REQ-030 On the cycle after reset deasserts, the block accepts start.

Structure
REQ-031 A shared package aes_pkg holds the state encoding, the Rcon table, and constants NR=10 and NB_BYTES=16.
REQ-032 One sub-module, aes_sbox (combinational 8-bit S-box lookup), is instantiated 4 times for SubWord.
REQ-033 Everything else resides in aes_key_expand.

Verification
REQ-034 Load key 2b7e151628aed2a6abf7158809cf4f3c, then next -> round 0 stream equals the key bytes, with rk_valid high for exactly 16 cycles.
REQ-035 Continue from REQ-034 with next -> round 1 stream = a0fafe1788542cb123a339392a6c7605; round 10 stream = d014f9a8c9ee2589e13f0cc8b6630ca6; done=1 after the last byte.
REQ-036 Same key loaded with random key_valid gaps -> identical round 1 key; ready rises exactly 1 cycle after the 16th accepted byte.
REQ-037 Pulse next during STREAM, during EXPAND, and in LOAD -> no effect; stream length stays 16 and round_idx is unchanged.
REQ-038 Assert reset at round 5 byte 7 -> the next cycle shows IDLE, rk_valid=0, and round_idx=0; a reload of the key then reproduces the round 1 key correctly.
REQ-039 Pulse start while in DONE -> done clears and a new key load of 000102030405060708090a0b0c0d0e0f yields round 10 key = 13111d7fe3944a17f307a78b4d2b30c5.
